// File: rtl/execute_pipe.sv
// uRISC execute stage: register file, single-cycle ALU/shift/branch, iterative
// shift-add multiplier, and a registered output slot with one-entry bypass.
module execute_pipe #(
  parameter  int DATA_W = 16,
  parameter  int NREGS  = 8,
  parameter  int MUL_EN = 1,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_idix,
  output logic              in_ready_idix,
  input  logic [3:0]        op_idix,
  input  logic [REG_AW-1:0] rs_idix,
  input  logic [REG_AW-1:0] rt_idix,
  input  logic [REG_AW-1:0] rd_idix,
  input  logic [DATA_W-1:0] imm_idix,
  input  logic              use_imm_idix,
  input  logic              wr_en_idix,
  input  logic [DATA_W-1:0] pc_idix,
  input  logic              flush,
  output logic              out_valid_ixmem,
  input  logic              out_ready_ixmem,
  output logic [DATA_W-1:0] result_ixmem,
  output logic [REG_AW-1:0] rd_ixmem,
  output logic              wr_ixmem,
  output logic              br_taken_ixmem,
  output logic [DATA_W-1:0] br_target_ixmem
);
  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR = 4'h3,
                         OP_XOR = 4'h4, OP_SLL = 4'h5, OP_SRL = 4'h6, OP_SRA = 4'h7,
                         OP_ROL = 4'h8, OP_ROR = 4'h9, OP_SLT = 4'hA, OP_MOV = 4'hB,
                         OP_MUL = 4'hC, OP_BEQZ = 4'hD, OP_BNEZ = 4'hE;

  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t r_state, w_state_nxt;

  logic [DATA_W-1:0] r_regs [NREGS];

  logic              r_out_valid;
  logic [DATA_W-1:0] r_result;
  logic [REG_AW-1:0] r_rd;
  logic              r_wr;
  logic              r_br_taken;
  logic [DATA_W-1:0] r_br_target;

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_mul_acc, r_mul_a, r_mul_b, r_mul_tgt;
  logic [REG_AW-1:0] r_mul_rd;
  logic              r_mul_wr;

  logic              w_in_ready, w_in_fire, w_out_fire, w_mul_start, w_mul_done;
  logic              w_byp;
  logic [DATA_W-1:0] w_a, w_rt_val, w_b, w_alu, w_tgt, w_mul_sum, w_rol, w_ror;
  logic [SH_W-1:0]   w_sh;
  logic [SH_W:0]     w_shc;
  logic              w_taken, w_writes;

  assign w_in_ready  = !rst && !flush && (r_state == S_IDLE) && (!r_out_valid || out_ready_ixmem);
  assign w_in_fire   = in_valid_idix && w_in_ready;
  assign w_out_fire  = r_out_valid && out_ready_ixmem && !flush;
  assign w_mul_start = w_in_fire && (op_idix == OP_MUL) && (MUL_EN != 0);
  assign w_mul_done  = (r_state == S_MUL) && (r_cnt == CNT_W'(1)) && !flush;

  // A slot that is accepting a new instruction is always retiring this edge,
  // so forwarding its result gives the same value the register file will hold.
  assign w_byp    = r_out_valid && r_wr;
  assign w_a      = (w_byp && r_rd == rs_idix) ? r_result : r_regs[rs_idix];
  assign w_rt_val = (w_byp && r_rd == rt_idix) ? r_result : r_regs[rt_idix];
  assign w_b      = use_imm_idix ? imm_idix : w_rt_val;

  assign w_sh  = w_b[SH_W-1:0];
  assign w_shc = (SH_W+1)'(DATA_W) - {1'b0, w_sh};
  assign w_rol = (w_a << w_sh) | (w_a >> w_shc);
  assign w_ror = (w_a >> w_sh) | (w_a << w_shc);
  assign w_tgt = pc_idix + imm_idix + {{(DATA_W-1){1'b0}}, 1'b1};

  always_comb begin
    w_alu    = '0;
    w_taken  = 1'b0;
    w_writes = wr_en_idix;
    case (op_idix)
      OP_ADD:  w_alu = w_a + w_b;
      OP_SUB:  w_alu = w_a - w_b;
      OP_AND:  w_alu = w_a & w_b;
      OP_OR:   w_alu = w_a | w_b;
      OP_XOR:  w_alu = w_a ^ w_b;
      OP_SLL:  w_alu = w_a << w_sh;
      OP_SRL:  w_alu = w_a >> w_sh;
      OP_SRA:  w_alu = $signed(w_a) >>> w_sh;
      OP_ROL:  w_alu = w_rol;
      OP_ROR:  w_alu = w_ror;
      OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      OP_MOV:  w_alu = w_b;
      OP_MUL:  w_alu = '0;  // only reaches the slot when the multiplier is absent
      OP_BEQZ: begin w_taken = (w_a == '0); w_writes = 1'b0; end
      OP_BNEZ: begin w_taken = (w_a != '0); w_writes = 1'b0; end
      default: w_writes = 1'b0;
    endcase
  end

  assign w_mul_sum = r_mul_acc + (r_mul_b[0] ? r_mul_a : '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_mul_start) w_state_nxt = S_MUL;
      S_MUL:   if (r_cnt == CNT_W'(1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_rd        <= '0;
      r_wr        <= 1'b0;
      r_br_taken  <= 1'b0;
      r_br_target <= '0;
      r_cnt       <= '0;
      r_mul_acc   <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_tgt   <= '0;
      r_mul_rd    <= '0;
      r_mul_wr    <= 1'b0;
    end else begin
      if (w_out_fire && r_wr) r_regs[r_rd] <= r_result;

      if (w_mul_start) begin
        r_cnt     <= CNT_W'(DATA_W);
        r_mul_acc <= '0;
        r_mul_a   <= w_a;
        r_mul_b   <= w_b;
        r_mul_tgt <= w_tgt;
        r_mul_rd  <= rd_idix;
        r_mul_wr  <= wr_en_idix;
      end else if (r_state == S_MUL) begin
        r_cnt     <= r_cnt - CNT_W'(1);
        r_mul_acc <= w_mul_sum;
        r_mul_a   <= r_mul_a << 1;
        r_mul_b   <= r_mul_b >> 1;
      end

      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_in_fire && !w_mul_start) begin
        r_out_valid <= 1'b1;
        r_result    <= w_alu;
        r_rd        <= rd_idix;
        r_wr        <= w_writes;
        r_br_taken  <= w_taken;
        r_br_target <= w_tgt;
      end else if (w_mul_done) begin
        r_out_valid <= 1'b1;
        r_result    <= w_mul_sum;
        r_rd        <= r_mul_rd;
        r_wr        <= r_mul_wr;
        r_br_taken  <= 1'b0;
        r_br_target <= r_mul_tgt;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready_idix   = w_in_ready;
  assign out_valid_ixmem = r_out_valid;
  assign result_ixmem    = r_result;
  assign rd_ixmem        = r_rd;
  assign wr_ixmem        = r_wr;
  assign br_taken_ixmem  = r_br_taken;
  assign br_target_ixmem = r_br_target;

endmodule

// File: tb/tb_execute_pipe.sv
// Bench for execute_pipe: directed vector table, hand-written multi-cycle
// sequences, and random traffic against an architectural scoreboard.
module tb_execute_pipe;
  localparam int W = 16, NR = 8, AW = 3;

  logic          clk = 1'b0, rst = 1'b1;
  logic          in_valid_idix = 1'b0, in_ready_idix;
  logic [3:0]    op_idix = '0;
  logic [AW-1:0] rs_idix = '0, rt_idix = '0, rd_idix = '0;
  logic [W-1:0]  imm_idix = '0, pc_idix = '0;
  logic          use_imm_idix = 1'b0, wr_en_idix = 1'b0, flush = 1'b0;
  logic          out_valid_ixmem, out_ready_ixmem = 1'b1;
  logic [W-1:0]  result_ixmem, br_target_ixmem;
  logic [AW-1:0] rd_ixmem;
  logic          wr_ixmem, br_taken_ixmem;

  always #5 clk = ~clk;

  execute_pipe #(.DATA_W(W), .NREGS(NR), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid_idix(in_valid_idix), .in_ready_idix(in_ready_idix),
    .op_idix(op_idix), .rs_idix(rs_idix), .rt_idix(rt_idix), .rd_idix(rd_idix),
    .imm_idix(imm_idix), .use_imm_idix(use_imm_idix), .wr_en_idix(wr_en_idix),
    .pc_idix(pc_idix), .flush(flush),
    .out_valid_ixmem(out_valid_ixmem), .out_ready_ixmem(out_ready_ixmem),
    .result_ixmem(result_ixmem), .rd_ixmem(rd_ixmem), .wr_ixmem(wr_ixmem),
    .br_taken_ixmem(br_taken_ixmem), .br_target_ixmem(br_target_ixmem)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_in(input logic [3:0] op, input int rs, input int rt, input int rd,
                        input logic [W-1:0] imm, input logic ui, input logic we,
                        input logic [W-1:0] pc);
    op_idix = op; rs_idix = AW'(rs); rt_idix = AW'(rt); rd_idix = AW'(rd);
    imm_idix = imm; use_imm_idix = ui; wr_en_idix = we; pc_idix = pc;
    in_valid_idix = 1'b1;
  endtask

  task automatic issue(input logic [3:0] op, input int rs, input int rt, input int rd,
                       input logic [W-1:0] imm, input logic ui, input logic we,
                       input logic [W-1:0] pc);
    int n = 0;
    set_in(op, rs, rt, rd, imm, ui, we, pc);
    #1;
    while (!in_ready_idix && n < 100) begin tick(); n++; end
    if (!in_ready_idix) chk("issue_timeout", 0, 1);
    tick();
    in_valid_idix = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid_ixmem && n < 100) begin tick(); n++; end
    if (!out_valid_ixmem) chk("out_timeout", 0, 1);
  endtask

  typedef struct {
    logic [3:0] op; logic [W-1:0] a, b, pc, imm, res, tgt; logic wr, tk;
  } vec_t;
  vec_t tv[$];

  typedef struct { logic [W-1:0] res, tgt; logic [AW-1:0] rd; logic wr, tk; } exp_t;
  exp_t q[$];
  logic [W-1:0] m_reg [NR];

  // Architectural result of one instruction, from the opcode definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, b, pc, imm,
                                 input logic [AW-1:0] rd, input logic we);
    exp_t e;
    longint ua = a, ub = b, r = 0, p2, sa, sb, qq;
    int sh = int'(b) % W;
    p2 = longint'(2) ** sh;
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    e.wr = we; e.tk = 1'b0; e.rd = rd;
    case (op)
      4'h0: r = ua + ub;
      4'h1: r = ua - ub + 65536;
      4'h2: r = longint'(a & b);
      4'h3: r = longint'(a | b);
      4'h4: r = longint'(a ^ b);
      4'h5: r = ua * p2;
      4'h6: r = ua / p2;
      4'h7: begin
        qq = (sa >= 0) ? sa / p2 : -((-sa + p2 - 1) / p2);
        r = qq + 65536;
      end
      4'h8: r = ((ua * p2) % 65536) + (ua * p2) / 65536;
      4'h9: begin
        p2 = longint'(2) ** ((W - sh) % W);
        r = ((ua * p2) % 65536) + (ua * p2) / 65536;
      end
      4'hA: r = (sa < sb) ? 1 : 0;
      4'hB: r = ub;
      4'hC: r = ua * ub;
      4'hD: begin e.tk = (a == 0); e.wr = 1'b0; end
      4'hE: begin e.tk = (a != 0); e.wr = 1'b0; end
      default: e.wr = 1'b0;
    endcase
    e.res = W'(r % 65536);
    e.tgt = W'((longint'(pc) + 1 + longint'(imm)) % 65536);
    return e;
  endfunction

  logic   m_ov, exp_rdy, acc, retire;
  int     mcnt;
  exp_t   e;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset ----
    tick(); tick();
    chk("rst_in_ready", in_ready_idix, 0);
    rst = 1'b0; #1;
    chk("rst_in_ready_after", in_ready_idix, 1);
    chk("rst_out_valid", out_valid_ixmem, 0);
    chk("rst_result", result_ixmem, 0);
    chk("rst_rd", rd_ixmem, 0);
    chk("rst_wr", wr_ixmem, 0);
    chk("rst_br_taken", br_taken_ixmem, 0);
    chk("rst_br_target", br_target_ixmem, 0);

    // ---- vector table: r1=a, r2=b, r3 = r1 op r2 ----
    tv.push_back('{4'h0, 16'h7FFF, 16'h0001, 16'h0100, 16'h0010, 16'h8000, 16'h0111, 1'b1, 1'b0});
    tv.push_back('{4'h1, 16'h0000, 16'h0001, 16'h0100, 16'h0010, 16'hFFFF, 16'h0111, 1'b1, 1'b0});
    tv.push_back('{4'h2, 16'hF0F0, 16'h3C3C, 16'h0100, 16'h0010, 16'h3030, 16'h0111, 1'b1, 1'b0});
    tv.push_back('{4'h3, 16'hF0F0, 16'h0F00, 16'h0100, 16'h0010, 16'hFFF0, 16'h0111, 1'b1, 1'b0});
    tv.push_back('{4'h4, 16'hFFFF, 16'h1234, 16'h0100, 16'h0010, 16'hEDCB, 16'h0111, 1'b1, 1'b0});
    tv.push_back('{4'h5, 16'h0001, 16'd17,   16'h0100, 16'h0010, 16'h0002, 16'h0111, 1'b1, 1'b0});
    tv.push_back('{4'h6, 16'h8000, 16'd4,    16'h0100, 16'h0010, 16'h0800, 16'h0111, 1'b1, 1'b0});
    tv.push_back('{4'h7, 16'h8000, 16'd15,   16'h0100, 16'h0010, 16'hFFFF, 16'h0111, 1'b1, 1'b0});
    tv.push_back('{4'h8, 16'h8001, 16'd1,    16'h0100, 16'h0010, 16'h0003, 16'h0111, 1'b1, 1'b0});
    tv.push_back('{4'h9, 16'h8001, 16'd1,    16'h0100, 16'h0010, 16'hC000, 16'h0111, 1'b1, 1'b0});
    tv.push_back('{4'hA, 16'hFFFF, 16'h0001, 16'h0100, 16'h0010, 16'h0001, 16'h0111, 1'b1, 1'b0});
    tv.push_back('{4'hA, 16'h0001, 16'hFFFF, 16'h0100, 16'h0010, 16'h0000, 16'h0111, 1'b1, 1'b0});
    tv.push_back('{4'hB, 16'h1111, 16'hABCD, 16'h0100, 16'h0010, 16'hABCD, 16'h0111, 1'b1, 1'b0});
    tv.push_back('{4'hC, 16'h00FF, 16'h0101, 16'h0100, 16'h0010, 16'hFFFF, 16'h0111, 1'b1, 1'b0});
    tv.push_back('{4'hC, 16'h1234, 16'h0010, 16'h0100, 16'h0010, 16'h2340, 16'h0111, 1'b1, 1'b0});
    tv.push_back('{4'hD, 16'h0000, 16'h5555, 16'hFFFE, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b1});
    tv.push_back('{4'hE, 16'h0000, 16'h5555, 16'h0200, 16'h0004, 16'h0000, 16'h0205, 1'b0, 1'b0});
    tv.push_back('{4'hE, 16'h0005, 16'h5555, 16'h0200, 16'h0004, 16'h0000, 16'h0205, 1'b0, 1'b1});
    tv.push_back('{4'hF, 16'h0005, 16'h5555, 16'h0300, 16'h0000, 16'h0000, 16'h0301, 1'b0, 1'b0});
    foreach (tv[i]) begin
      issue(4'hB, 0, 0, 1, tv[i].a, 1'b1, 1'b1, 16'h0);
      issue(4'hB, 0, 0, 2, tv[i].b, 1'b1, 1'b1, 16'h0);
      issue(tv[i].op, 1, 2, 3, tv[i].imm, 1'b0, 1'b1, tv[i].pc);
      wait_out();
      chk($sformatf("vec%0d_result", i), result_ixmem, tv[i].res);
      chk($sformatf("vec%0d_wr", i), wr_ixmem, tv[i].wr);
      chk($sformatf("vec%0d_br_taken", i), br_taken_ixmem, tv[i].tk);
      chk($sformatf("vec%0d_br_target", i), br_target_ixmem, tv[i].tgt);
    end
    tick();

    // ---- dependent chain through the bypass ----
    set_in(4'hB, 0, 0, 1, 16'h7FFF, 1'b1, 1'b1, 16'h0); #1;
    chk("chain_rdy0", in_ready_idix, 1); tick();
    chk("chain_res0", result_ixmem, 16'h7FFF);
    set_in(4'h0, 1, 0, 2, 16'h0001, 1'b1, 1'b1, 16'h0); #1;
    chk("chain_rdy1", in_ready_idix, 1); tick();
    chk("chain_res1", result_ixmem, 16'h8000);
    set_in(4'hA, 2, 0, 3, 16'h0000, 1'b1, 1'b1, 16'h0); #1;
    chk("chain_rdy2", in_ready_idix, 1); tick();
    chk("chain_res2", result_ixmem, 16'h0001);
    in_valid_idix = 1'b0; tick();

    // ---- backpressure ----
    out_ready_ixmem = 1'b0;
    issue(4'hB, 0, 0, 4, 16'h5A5A, 1'b1, 1'b1, 16'h0);
    set_in(4'h0, 4, 0, 4, 16'h0001, 1'b1, 1'b1, 16'h0); #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", out_valid_ixmem, 1);
      chk("bp_result", result_ixmem, 16'h5A5A);
      chk("bp_rd", rd_ixmem, 4);
      chk("bp_in_ready", in_ready_idix, 0);
      tick();
    end
    out_ready_ixmem = 1'b1; #1;
    chk("bp_ready_rise", in_ready_idix, 1);
    tick();
    chk("bp_next_result", result_ixmem, 16'h5A5B);
    set_in(4'h0, 4, 0, 5, 16'h0000, 1'b1, 1'b1, 16'h0); tick();
    chk("bp_reg_once", result_ixmem, 16'h5A5B);
    in_valid_idix = 1'b0; tick();

    // ---- MUL latency ----
    issue(4'hB, 0, 0, 1, 16'h00FF, 1'b1, 1'b1, 16'h0);
    issue(4'hB, 0, 0, 2, 16'h0101, 1'b1, 1'b1, 16'h0);
    issue(4'hC, 1, 2, 3, 16'h0000, 1'b0, 1'b1, 16'h0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("mul_busy_rdy%0d", k), in_ready_idix, 0);
      chk($sformatf("mul_busy_ov%0d", k), out_valid_ixmem, 0);
      tick();
    end
    chk("mul_done_valid", out_valid_ixmem, 1);
    chk("mul_done_result", result_ixmem, 16'hFFFF);
    chk("mul_done_rd", rd_ixmem, 3);
    issue(4'h0, 3, 0, 6, 16'h0000, 1'b1, 1'b1, 16'h0);
    chk("mul_r3_readback", result_ixmem, 16'hFFFF);

    // ---- flush mid-MUL ----
    issue(4'hC, 1, 2, 3, 16'h0000, 1'b0, 1'b1, 16'h0);
    repeat (4) tick();
    flush = 1'b1; #1;
    chk("flush_mul_rdy", in_ready_idix, 0);
    tick(); flush = 1'b0; #1;
    chk("flush_mul_rdy_after", in_ready_idix, 1);
    for (int k = 0; k < 20; k++) begin
      chk("flush_mul_no_out", out_valid_ixmem, 0);
      tick();
    end

    // ---- flush drops a retiring slot ----
    issue(4'hB, 0, 0, 7, 16'h2222, 1'b1, 1'b1, 16'h0);
    tick();
    issue(4'hB, 0, 0, 7, 16'h1111, 1'b1, 1'b1, 16'h0);
    flush = 1'b1; tick(); flush = 1'b0; #1;
    chk("flush_slot_ov", out_valid_ixmem, 0);
    chk("flush_slot_rdy", in_ready_idix, 1);
    issue(4'h0, 7, 0, 0, 16'h0000, 1'b1, 1'b0, 16'h0);
    chk("flush_slot_r7", result_ixmem, 16'h2222);

    // ---- reset mid-MUL clears everything ----
    issue(4'hC, 1, 2, 3, 16'h0000, 1'b0, 1'b1, 16'h0);
    repeat (3) tick();
    rst = 1'b1; #1;
    chk("rst_mul_rdy", in_ready_idix, 0);
    tick(); rst = 1'b0; #1;
    chk("rst_mul_rdy_after", in_ready_idix, 1);
    chk("rst_mul_ov", out_valid_ixmem, 0);
    chk("rst_mul_result", result_ixmem, 0);
    tick();

    // ---- random traffic against scoreboard ----
    for (int i = 0; i < NR; i++) m_reg[i] = '0;
    m_ov = 1'b0; mcnt = 0;
    for (int cyc = 0; cyc < 3050; cyc++) begin
      flush = (cyc < 3000) && ($urandom_range(0, 39) == 0);
      out_ready_ixmem = (cyc >= 3000) || ($urandom_range(0, 3) != 0);
      if (cyc >= 3000) in_valid_idix = 1'b0;
      else if (!in_valid_idix && $urandom_range(0, 2) != 0) begin
        op_idix = 4'($urandom_range(0, 15));
        if (op_idix == 4'hC && $urandom_range(0, 3) != 0) op_idix = 4'h0;
        rs_idix = AW'($urandom_range(0, NR-1));
        rt_idix = AW'($urandom_range(0, NR-1));
        rd_idix = AW'($urandom_range(0, NR-1));
        case ($urandom_range(0, 5))
          0: imm_idix = 16'h0000;
          1: imm_idix = 16'hFFFF;
          2: imm_idix = 16'h8000;
          3: imm_idix = 16'h7FFF;
          4: imm_idix = 16'h0001;
          default: imm_idix = 16'($urandom);
        endcase
        use_imm_idix = 1'($urandom_range(0, 1));
        wr_en_idix = ($urandom_range(0, 4) != 0);
        pc_idix = 16'($urandom);
        in_valid_idix = 1'b1;
      end
      #1;
      exp_rdy = !flush && (mcnt == 0) && (!m_ov || out_ready_ixmem);
      chk("rnd_in_ready", in_ready_idix, exp_rdy);
      chk("rnd_out_valid", out_valid_ixmem, m_ov);
      retire = m_ov && out_ready_ixmem && !flush;
      acc = in_valid_idix && exp_rdy;
      if (retire && q.size() > 0) begin
        chk("rnd_result", result_ixmem, q[0].res);
        chk("rnd_rd", rd_ixmem, q[0].rd);
        chk("rnd_wr", wr_ixmem, q[0].wr);
        chk("rnd_br_taken", br_taken_ixmem, q[0].tk);
        chk("rnd_br_target", br_target_ixmem, q[0].tgt);
        if (q[0].wr) m_reg[q[0].rd] = q[0].res;
        void'(q.pop_front());
        m_ov = 1'b0;
      end
      if (flush) begin
        q.delete(); m_ov = 1'b0; mcnt = 0;
      end else begin
        if (mcnt == 1) begin m_ov = 1'b1; mcnt = 0; end
        else if (mcnt > 1) mcnt--;
        if (acc) begin
          e = model(op_idix, m_reg[rs_idix],
                    use_imm_idix ? imm_idix : m_reg[rt_idix],
                    pc_idix, imm_idix, rd_idix, wr_en_idix);
          q.push_back(e);
          if (op_idix == 4'hC) mcnt = W;
          else m_ov = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (acc) in_valid_idix = 1'b0;
    end
    flush = 1'b0; out_ready_ixmem = 1'b1;

    // ---- read every register back architecturally ----
    for (int r = 0; r < NR; r++) begin
      issue(4'h0, r, 0, 0, 16'h0000, 1'b1, 1'b0, 16'h0);
      chk($sformatf("final_r%0d", r), result_ixmem, m_reg[r]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
